// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_pkg : shared widths and enums for the memory bus scheduler
// Revision    : 1.0 initial release
// ----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int WORD_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/mem_bus_sched_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2  : combinational two-way pick between fetch and data requests
// Revision : 1.0 initial release
// ----------------------------------------------------------------------------
module rr_arb2
    import mem_bus_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic winner_o,
    output logic valid_o
);

    logic w_rr_pick;
    logic w_tie_pick;

    // Round-robin hands a tie to whoever did not win last time.
    assign w_rr_pick  = (last_grant_i == REQ_D) ? REQ_IF : REQ_D;
    assign w_tie_pick = (PRIORITY_MODE == 1) ? REQ_D : w_rr_pick;
    assign valid_o    = if_req_i | d_req_i;

    always_comb begin
        winner_o = REQ_IF;
        if (if_req_i && d_req_i) begin
            winner_o = w_tie_pick;
        end else if (d_req_i) begin
            winner_o = REQ_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_sched : arbitrates fetch/data requesters onto one memory bus and
//                 sequences SETUP/ACCESS with wait states.
//                 Optional access timeout: define MEM_BUS_TIMEOUT_EN.
// Revision      : 1.0 initial release
// ----------------------------------------------------------------------------
module mem_bus_sched
    import mem_bus_pkg::*;
#(
    parameter int WAIT_CYCLES   = 0,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              EN_ADDRESS_PC,
    output logic              EN_ADDRESS_ALU,
    output logic              MR,
    output logic              MW,
    output logic              busy,
    output logic              bus_err
);

    localparam logic [WAIT_W-1:0] c_WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_e            state_q,   state_d;
    req_id_e           last_q,    last_d;
    req_id_e           who_q,     who_d;
    logic              we_q,      we_d;
    logic [WORD_W-1:0] addr_q,    addr_d;
    logic [WORD_W-1:0] wdata_q,   wdata_d;
    logic [WORD_W-1:0] rdata_q,   rdata_d;
    logic [WAIT_W-1:0] wcnt_q,    wcnt_d;
    logic              if_gnt_q,  if_gnt_d;
    logic              d_gnt_q,   d_gnt_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q,  d_done_d;
    logic              en_pc_q,   en_pc_d;
    logic              en_alu_q,  en_alu_d;
    logic              mr_q,      mr_d;
    logic              mw_q,      mw_d;
    logic              busy_q,    busy_d;
    logic              berr_q,    berr_d;

    logic              w_winner;
    logic              w_valid;
    logic              w_complete;
    logic              w_timeout;

    rr_arb2 #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .last_grant_i (last_q),
        .winner_o     (w_winner),
        .valid_o      (w_valid)
    );

    assign w_complete = (wcnt_q == '0) && mem_rdy;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int              c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [c_TO_W-1:0] tcnt_q, tcnt_d;

    // tcnt holds the number of ACCESS cycles already spent; the last one aborts.
    assign w_timeout = (tcnt_q == c_TO_LAST);

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == SETUP) begin
            tcnt_d = '0;
        end else if (state_q == ACCESS && !w_complete && !w_timeout) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        who_d     = who_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wcnt_d    = wcnt_q;
        en_pc_d   = en_pc_q;
        en_alu_d  = en_alu_q;
        mr_d      = mr_q;
        mw_d      = mw_q;
        busy_d    = busy_q;
        if_gnt_d  = 1'b0;
        d_gnt_d   = 1'b0;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        berr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_valid) begin
                    state_d = SETUP;
                    who_d   = req_id_e'(w_winner);
                    last_d  = req_id_e'(w_winner);
                    busy_d  = 1'b1;
                    if (w_winner == REQ_D) begin
                        d_gnt_d  = 1'b1;
                        en_alu_d = 1'b1;
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                    end else begin
                        if_gnt_d = 1'b1;
                        en_pc_d  = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                mr_d    = ~we_q;
                mw_d    = we_q;
                wcnt_d  = c_WAIT_INIT;
            end
            ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end
                if (w_complete || w_timeout) begin
                    state_d  = IDLE;
                    en_pc_d  = 1'b0;
                    en_alu_d = 1'b0;
                    mr_d     = 1'b0;
                    mw_d     = 1'b0;
                    busy_d   = 1'b0;
                    if (who_q == REQ_D) begin
                        d_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                    // A completed access wins over a timeout landing on the same edge.
                    if (w_complete) begin
                        if (!we_q) begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        berr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= REQ_D;
            who_q     <= REQ_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wcnt_q    <= '0;
            if_gnt_q  <= 1'b0;
            d_gnt_q   <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            en_pc_q   <= 1'b0;
            en_alu_q  <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            busy_q    <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            who_q     <= who_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wcnt_q    <= wcnt_d;
            if_gnt_q  <= if_gnt_d;
            d_gnt_q   <= d_gnt_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
            en_pc_q   <= en_pc_d;
            en_alu_q  <= en_alu_d;
            mr_q      <= mr_d;
            mw_q      <= mw_d;
            busy_q    <= busy_d;
            berr_q    <= berr_d;
        end
    end

    assign if_gnt         = if_gnt_q;
    assign d_gnt          = d_gnt_q;
    assign if_done        = if_done_q;
    assign d_done         = d_done_q;
    assign rdata          = rdata_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign EN_ADDRESS_PC  = en_pc_q;
    assign EN_ADDRESS_ALU = en_alu_q;
    assign MR             = mr_q;
    assign MW             = mw_q;
    assign busy           = busy_q;
    assign bus_err        = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_sched : two scheduler instances (round-robin/no wait, fixed
//                    priority/3 waits) against a transaction-level model.
// Revision         : 1.0 initial release
// ----------------------------------------------------------------------------
module tb_mem_bus_sched;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_rdy = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;

    logic [1:0]  o_if_gnt, o_if_done, o_d_gnt, o_d_done;
    logic [1:0]  o_en_pc, o_en_alu, o_mr, o_mw, o_busy, o_bus_err;
    logic [15:0] o_rdata [2];
    logic [15:0] o_maddr [2];
    logic [15:0] o_mwdat [2];

    always #5 clk = ~clk;

    mem_bus_sched #(.WAIT_CYCLES(0), .PRIORITY_MODE(0), .TIMEOUT(TO)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]), .if_done(o_if_done[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(o_d_gnt[0]), .d_done(o_d_done[0]), .rdata(o_rdata[0]),
        .mem_addr(o_maddr[0]), .mem_wdata(o_mwdat[0]), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .EN_ADDRESS_PC(o_en_pc[0]), .EN_ADDRESS_ALU(o_en_alu[0]), .MR(o_mr[0]), .MW(o_mw[0]),
        .busy(o_busy[0]), .bus_err(o_bus_err[0])
    );

    mem_bus_sched #(.WAIT_CYCLES(3), .PRIORITY_MODE(1), .TIMEOUT(TO)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]), .if_done(o_if_done[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(o_d_gnt[1]), .d_done(o_d_done[1]), .rdata(o_rdata[1]),
        .mem_addr(o_maddr[1]), .mem_wdata(o_mwdat[1]), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .EN_ADDRESS_PC(o_en_pc[1]), .EN_ADDRESS_ALU(o_en_alu[1]), .MR(o_mr[1]), .MW(o_mw[1]),
        .busy(o_busy[1]), .bus_err(o_bus_err[1])
    );

    int n_vec = 0;
    int n_mis = 0;

    int P_WAIT [2] = '{0, 3};
    int P_PM   [2] = '{0, 1};

    // Expected outputs; flags = {if_gnt,d_gnt,if_done,d_done,en_pc,en_alu,MR,MW,busy,bus_err}
    typedef struct {
        logic [9:0]  flags;
        logic [15:0] rdata;
        logic [15:0] maddr;
        logic [15:0] mwdat;
    } exp_t;

    localparam logic [9:0] F_IG = 10'h200, F_DG = 10'h100, F_ID = 10'h080, F_DD = 10'h040;
    localparam logic [9:0] F_EP = 10'h020, F_EA = 10'h010, F_MR = 10'h008, F_MW = 10'h004;
    localparam logic [9:0] F_BY = 10'h002, F_BE = 10'h001;

    exp_t e [2];
    bit   m_act  [2];
    int   m_age  [2];   // cycles since grant: 1 = setup, n>1 = access cycle n-1
    int   m_who  [2];   // 0 fetch, 1 data
    int   m_last [2];
    bit   m_we   [2];

    function automatic logic [9:0] dut_flags(int d);
        return {o_if_gnt[d], o_d_gnt[d], o_if_done[d], o_d_done[d], o_en_pc[d],
                o_en_alu[d], o_mr[d], o_mw[d], o_busy[d], o_bus_err[d]};
    endfunction

    task automatic chk(string name, logic [31:0] actv, logic [31:0] expv);
        n_vec++;
        if (actv !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actv, expv, $time);
        end
    endtask

    task automatic model_reset(int d);
        m_act[d]  = 1'b0;
        m_age[d]  = 0;
        m_who[d]  = 0;
        m_last[d] = 1;
        m_we[d]   = 1'b0;
        e[d].flags = '0;
        e[d].rdata = '0;
        e[d].maddr = '0;
        e[d].mwdat = '0;
    endtask

    task automatic model_edge(int d);
        int  k;
        bit  fin;
        logic [9:0] f;
        f = e[d].flags & ~(F_IG | F_DG | F_ID | F_DD | F_BE);
        if (!m_act[d]) begin
            if (if_req || d_req) begin
                if (if_req && d_req) m_who[d] = (P_PM[d] == 1) ? 1 : ((m_last[d] == 1) ? 0 : 1);
                else                 m_who[d] = d_req ? 1 : 0;
                m_last[d] = m_who[d];
                m_act[d]  = 1'b1;
                m_age[d]  = 1;
                if (m_who[d] == 1) begin
                    f = f | F_DG | F_EA | F_BY;
                    m_we[d] = d_we;
                    e[d].maddr = d_addr;
                    e[d].mwdat = d_wdata;
                end else begin
                    f = f | F_IG | F_EP | F_BY;
                    m_we[d] = 1'b0;
                    e[d].maddr = if_addr;
                end
            end
        end else if (m_age[d] == 1) begin
            m_age[d] = 2;
            f = f | (m_we[d] ? F_MW : F_MR);
        end else begin
            k   = m_age[d] - 1;
            fin = 1'b0;
            if (k > P_WAIT[d] && mem_rdy) begin
                fin = 1'b1;
                if (!m_we[d]) e[d].rdata = mem_rdata;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            if (!fin && k == TO) begin
                fin = 1'b1;
                f = f | F_BE;
            end
`endif
            if (fin) begin
                m_act[d] = 1'b0;
                f = (f & ~(F_EP | F_EA | F_MR | F_MW | F_BY)) | ((m_who[d] == 1) ? F_DD : F_ID);
            end else begin
                m_age[d] = m_age[d] + 1;
            end
        end
        e[d].flags = f;
    endtask

    task automatic compare(int d);
        logic [9:0] f;
        f = dut_flags(d);
        chk($sformatf("u%0d.flags", d), {22'd0, f}, {22'd0, e[d].flags});
        chk($sformatf("u%0d.rdata", d), {16'd0, o_rdata[d]}, {16'd0, e[d].rdata});
        chk($sformatf("u%0d.mem_addr", d), {16'd0, o_maddr[d]}, {16'd0, e[d].maddr});
        chk($sformatf("u%0d.mem_wdata", d), {16'd0, o_mwdat[d]}, {16'd0, e[d].mwdat});
        chk($sformatf("u%0d.en_overlap", d), {31'd0, o_en_pc[d] & o_en_alu[d]}, 32'd0);
        chk($sformatf("u%0d.strobe_overlap", d), {31'd0, o_mr[d] & o_mw[d]}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
    endtask

    typedef struct {
        logic        ifr, dr, we, rdy;
        logic [15:0] ia, da, wd, rd;
        logic [9:0]  flags;
        logic [15:0] rdata, maddr;
    } vec_t;

    function automatic vec_t mk(logic ifr, logic dr, logic we, logic [15:0] ia, logic [15:0] da,
                                logic [15:0] wd, logic rdy, logic [15:0] rd, logic [9:0] flags,
                                logic [15:0] rdata, logic [15:0] maddr);
        vec_t v;
        v.ifr = ifr; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd;
        v.rdy = rdy; v.rd = rd; v.flags = flags; v.rdata = rdata; v.maddr = maddr;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        int cnt_ig, cnt_dg, cnt_ig1, cnt_mr, diff;
        // Expected u0 outputs (round-robin, zero wait) after each edge.
        tbl[0]  = mk(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h1234, F_IG | F_EP | F_BY, 16'h0000, 16'h0010);
        tbl[1]  = mk(0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h1234, F_EP | F_MR | F_BY, 16'h0000, 16'h0010);
        tbl[2]  = mk(0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h1234, F_ID,               16'h1234, 16'h0010);
        tbl[3]  = mk(1, 1, 0, 16'h0020, 16'h0200, 16'h0000, 1, 16'h5555, F_DG | F_EA | F_BY, 16'h1234, 16'h0200);
        tbl[4]  = mk(0, 0, 0, 16'h0020, 16'h0200, 16'h0000, 1, 16'h5555, F_EA | F_MR | F_BY, 16'h1234, 16'h0200);
        tbl[5]  = mk(0, 0, 0, 16'h0020, 16'h0200, 16'h0000, 1, 16'h5555, F_DD,               16'h5555, 16'h0200);
        tbl[6]  = mk(1, 1, 1, 16'h0020, 16'h0300, 16'hABCD, 1, 16'h5555, F_IG | F_EP | F_BY, 16'h5555, 16'h0020);
        tbl[7]  = mk(0, 1, 1, 16'h0020, 16'h0300, 16'hABCD, 1, 16'h5555, F_EP | F_MR | F_BY, 16'h5555, 16'h0020);
        tbl[8]  = mk(0, 1, 1, 16'h0020, 16'h0300, 16'hABCD, 1, 16'h7777, F_ID,               16'h7777, 16'h0020);
        tbl[9]  = mk(0, 1, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h7777, F_DG | F_EA | F_BY, 16'h7777, 16'h8000);
        tbl[10] = mk(0, 0, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h7777, F_EA | F_MW | F_BY, 16'h7777, 16'h8000);
        tbl[11] = mk(0, 0, 1, 16'h0020, 16'h8000, 16'hBEEF, 0, 16'h7777, F_EA | F_MW | F_BY, 16'h7777, 16'h8000);
        tbl[12] = mk(0, 0, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h9999, F_DD,               16'h7777, 16'h8000);
        tbl[13] = mk(0, 0, 0, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h9999, 10'h000,            16'h7777, 16'h8000);

        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        compare(0);
        compare(1);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if_req = tbl[i].ifr; d_req = tbl[i].dr; d_we = tbl[i].we;
            if_addr = tbl[i].ia; d_addr = tbl[i].da; d_wdata = tbl[i].wd;
            mem_rdy = tbl[i].rdy; mem_rdata = tbl[i].rd;
            step();
            chk($sformatf("tbl%0d.flags", i), {22'd0, dut_flags(0)}, {22'd0, tbl[i].flags});
            chk($sformatf("tbl%0d.rdata", i), {16'd0, o_rdata[0]}, {16'd0, tbl[i].rdata});
            chk($sformatf("tbl%0d.mem_addr", i), {16'd0, o_maddr[0]}, {16'd0, tbl[i].maddr});
        end

        // Both requesters held: u0 alternates, u1 (fixed priority) only serves data.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_rdy = 1'b1;
        cnt_ig = 0; cnt_dg = 0; cnt_ig1 = 0;
        for (int i = 0; i < 24; i++) begin
            if_addr = 16'h1000 + 16'(i); d_addr = 16'h2000 + 16'(i); mem_rdata = 16'h3000 + 16'(i);
            step();
            cnt_ig  += int'(o_if_gnt[0]);
            cnt_dg  += int'(o_d_gnt[0]);
            cnt_ig1 += int'(o_if_gnt[1]);
        end
        diff = cnt_ig - cnt_dg;
        chk("rr_balance", {31'd0, (diff <= 1 && diff >= -1)}, 32'd1);
        chk("rr_grants", {31'd0, (cnt_ig + cnt_dg >= 7)}, 32'd1);
        chk("pri_if_gnt_count", 32'(cnt_ig1), 32'd0);

        // Reset in the middle of a fetch access.
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) step();
        if_req = 1'b1; if_addr = 16'h0030; mem_rdy = 1'b0;
        step();
        if_req = 1'b0;
        for (int i = 0; i < 10 && !e[0].flags[3]; i++) step();
        chk("reach_access", {31'd0, e[0].flags[3]}, 32'd1);
        reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare(0);
        compare(1);
        chk("rst_mr", {31'd0, o_mr[0]}, 32'd0);
        chk("rst_en_pc", {31'd0, o_en_pc[0]}, 32'd0);
        #2;
        reset = 1'b1;
        mem_rdy = 1'b1;
        repeat (4) step();
        if_req = 1'b1; if_addr = 16'h0040; mem_rdata = 16'h4242;
        step();
        chk("post_rst_gnt", {31'd0, o_if_gnt[0]}, 32'd1);
        if_req = 1'b0;
        step();
        chk("post_rst_mr", {31'd0, o_mr[0]}, 32'd1);
        step();
        chk("post_rst_done", {31'd0, o_if_done[0]}, 32'd1);
        chk("post_rst_rdata", {16'd0, o_rdata[0]}, 32'h4242);
        repeat (6) step();

`ifdef MEM_BUS_TIMEOUT_EN
        if_req = 1'b1; mem_rdy = 1'b0;
        step();
        if_req = 1'b0;
        cnt_mr = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt_mr += int'(o_mr[0]);
        end
        chk("timeout_mr_cycles", 32'(cnt_mr), 32'(TO));
        mem_rdy = 1'b1;
`else
        cnt_mr = 0;
`endif

        for (int i = 0; i < 600; i++) begin
            if_req    = ($urandom_range(0, 2) == 0);
            d_req     = ($urandom_range(0, 2) == 0);
            d_we      = 1'($urandom_range(0, 1));
            if_addr   = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_rdy   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
